// File: rtl/zone_harvest_detector_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | farm_pkg                                                          |
// | Shared types, defaults and helpers for the zone harvest detector. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package farm_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        EVAL       = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_ZONES = 4;
    localparam int DEF_ZONE_PIX  = 40;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_CONFIRM   = 3;

    // Alert when at least half of the zones (rounded up) are ready.
    function automatic logic harvest_majority(input int unsigned level, input int unsigned zones);
        return level >= (zones + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zone_harvest_detector_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zone_harvest_detector_if                                          |
// | Camera pixel stream with HREF/VSYNC framing.                      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface zone_harvest_detector_if #(
    parameter int DATA_W = 8
);
    logic              href;
    logic              vsync;
    logic [DATA_W-1:0] data;

    modport master (output href, vsync, data);
    modport slave  (input  href, vsync, data);
endinterface
`default_nettype wire

// File: rtl/zone_harvest_detector_zone_confirm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zone_confirm                                                      |
// | Per-zone saturating green counter and consecutive-frame confirm.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module zone_confirm #(
    parameter int CNT_W   = 16,
    parameter int CONFIRM = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             inc,
    input  wire logic             eval,
    input  wire logic [CNT_W-1:0] zone_thresh,
    output logic                  ready,
    output logic                  ready_eval,
    output logic                  sat_hit
);
    localparam int CONF_W = $clog2(CONFIRM + 1);

    logic [CNT_W-1:0]  count;
    logic [CONF_W-1:0] conf;
    logic [CONF_W-1:0] conf_nxt;

    assign sat_hit = inc && (count == '1);

    always_comb begin
        conf_nxt = '0;
        if (count >= zone_thresh) begin
            conf_nxt = (conf == CONF_W'(CONFIRM)) ? conf : conf + CONF_W'(1);
        end
        ready_eval = (conf_nxt == CONF_W'(CONFIRM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            conf  <= '0;
            ready <= 1'b0;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (inc && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
            if (eval) begin
                conf  <= conf_nxt;
                ready <= ready_eval;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/zone_harvest_detector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zone_harvest_detector                                             |
// | Splits each camera line into column zones and flags ready trays.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module zone_harvest_detector
    import farm_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_ZONES = DEF_NUM_ZONES,
    parameter int ZONE_PIX  = DEF_ZONE_PIX,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int CONFIRM   = DEF_CONFIRM
) (
    input  wire logic                             clk,
    input  wire logic                             rst,
    zone_harvest_detector_if.slave                cam,
    input  wire logic [DATA_W-1:0]                green_thresh,
    input  wire logic [CNT_W-1:0]                 zone_thresh,
    output logic [NUM_ZONES-1:0]                  zone_ready,
    output logic [$clog2(NUM_ZONES+1)-1:0]        alert_level,
    output logic                                  harvest_alert,
    output logic                                  frame_done,
    output logic                                  fault_detected
);
    localparam int LVL_W  = $clog2(NUM_ZONES + 1);
    localparam int ZIDX_W = $clog2(NUM_ZONES + 1);
    localparam int SUB_W  = (ZONE_PIX > 1) ? $clog2(ZONE_PIX) : 1;

    state_t             state, state_nxt;
    logic               vs_d;
    logic               frame_start, frame_end;
    logic               frame_entry, pix_en, eval_en;
    logic [DATA_W-1:0]  gthr_sh;
    logic [CNT_W-1:0]   zthr_sh;
    logic [ZIDX_W-1:0]  zone_idx;
    logic [SUB_W-1:0]   sub_cnt;
    logic [NUM_ZONES-1:0] ready_eval;
    logic [NUM_ZONES-1:0] sat_hit;
    logic [LVL_W-1:0]   level_nxt;

    assign frame_start = vs_d && !cam.vsync;
    assign frame_end   = !vs_d && cam.vsync;

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_FRAME;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_FRAME: if (frame_start) state_nxt = ACTIVE;
            ACTIVE:     if (frame_end)   state_nxt = EVAL;
            EVAL:       state_nxt = frame_start ? ACTIVE : WAIT_FRAME;
            default:    state_nxt = WAIT_FRAME;
        endcase
    end

    always_comb begin
        frame_entry = frame_start && (state != ACTIVE);
        pix_en      = (state == ACTIVE) && cam.href;
        eval_en     = (state == EVAL);
    end

    // Column position within the line; zone_idx parks at NUM_ZONES so trailing pixels are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d     <= 1'b0;
            gthr_sh  <= '0;
            zthr_sh  <= '0;
            zone_idx <= '0;
            sub_cnt  <= '0;
        end else begin
            vs_d <= cam.vsync;
            if (frame_entry) begin
                gthr_sh  <= green_thresh;
                zthr_sh  <= zone_thresh;
                zone_idx <= '0;
                sub_cnt  <= '0;
            end else if (state == ACTIVE && !cam.href) begin
                zone_idx <= '0;
                sub_cnt  <= '0;
            end else if (pix_en) begin
                if (sub_cnt == SUB_W'(ZONE_PIX - 1)) begin
                    sub_cnt <= '0;
                    if (zone_idx != ZIDX_W'(NUM_ZONES)) zone_idx <= zone_idx + ZIDX_W'(1);
                end else begin
                    sub_cnt <= sub_cnt + SUB_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
        zone_confirm #(
            .CNT_W   (CNT_W),
            .CONFIRM (CONFIRM)
        ) u_zone (
            .clk         (clk),
            .rst         (rst),
            .clear       (frame_entry),
            .inc         (pix_en && (zone_idx == ZIDX_W'(i)) && (cam.data > gthr_sh)),
            .eval        (eval_en),
            .zone_thresh (zthr_sh),
            .ready       (zone_ready[i]),
            .ready_eval  (ready_eval[i]),
            .sat_hit     (sat_hit[i])
        );
    end

    always_comb begin
        level_nxt = '0;
        for (int i = 0; i < NUM_ZONES; i++) level_nxt = level_nxt + LVL_W'(ready_eval[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alert_level    <= '0;
            harvest_alert  <= 1'b0;
            frame_done     <= 1'b0;
            fault_detected <= 1'b0;
        end else begin
            frame_done <= eval_en;
            if (eval_en) begin
                alert_level   <= level_nxt;
                harvest_alert <= harvest_majority(32'(level_nxt), NUM_ZONES);
            end
            if (|sat_hit) fault_detected <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: doc/zone_harvest_detector.md
# zone_harvest_detector

Parametrised per-zone harvest-readiness detector for the precision-farming ASIC. It consumes the 8-bit camera pixel stream (HREF/VSYNC framing) and splits each line into `NUM_ZONES` equal column zones, one per tray. It counts "green" pixels per zone over a frame and confirms a zone ready only after `CONFIRM` consecutive qualifying frames. It drives per-zone ready flags, an alert level, the harvest alert and a sticky fault, and replaces the single-region harvest decision behind the top-level wrapper.

## Interface
Parameters:
- `DATA_W`, 8, pixel width
- `NUM_ZONES`, 4, column zones per line (≥1)
- `ZONE_PIX`, 40, pixels per zone per line
- `CNT_W`, 16, per-zone green-count width
- `CONFIRM`, 3, consecutive qualifying frames required (≥1)

Ports:
- `clk`  in  1  system clock; camera pixel clock is the same clock
- `rst`  in  1  synchronous, active-high reset
- `cam_href`  in  1  line valid; pixel accepted each cycle it is high
- `cam_vsync`  in  1  high = vertical blanking
- `cam_data`  in  DATA_W  pixel value
- `green_thresh`  in  DATA_W  pixel counts as green when `cam_data > green_thresh`
- `zone_thresh`  in  CNT_W  frame qualifies for a zone when its count ≥ `zone_thresh`
- `zone_ready`  out  NUM_ZONES  zone confirmed ready
- `alert_level`  out  $clog2(NUM_ZONES+1)  number of set `zone_ready` bits
- `harvest_alert`  out  1  `alert_level` ≥ ceil(NUM_ZONES/2)
- `frame_done`  out  1  one-cycle pulse when outputs refresh
- `fault_detected`  out  1  sticky: a zone counter saturated

## Operation
- VSYNC edge detect uses `vs_d`, which is registered `cam_vsync` and resets to 0.
  - Frame start = `vs_d`=1 and `cam_vsync`=0.
  - Frame end = `vs_d`=0 and `cam_vsync`=1.
- FSM states: WAIT_FRAME (reset state), ACTIVE, EVAL.
- WAIT_FRAME → ACTIVE on frame start. On entry:
  - clear all green counters, column counters and the per-frame saturation flag;
  - latch `green_thresh` and `zone_thresh` into shadow registers (mid-frame changes have no effect).
- ACTIVE: each cycle with `cam_href`=1:
  - `zone_idx`/`sub_cnt` counters advance; no divider. `sub_cnt` wraps at `ZONE_PIX`-1, then `zone_idx` increments.
  - If `zone_idx` < NUM_ZONES and pixel > shadow `green_thresh`, the counter of that zone increments, saturating at 2^CNT_W-1.
  - An increment attempted at saturation sets `fault_detected`.
  - Pixels with `zone_idx` ≥ NUM_ZONES are ignored.
  - `zone_idx`/`sub_cnt` clear on the cycle after `cam_href` falls (line end).
- ACTIVE → EVAL on frame end. A pixel with `cam_href`=1 in the frame-end cycle is still counted.
- EVAL (exactly 1 cycle), for each zone i:
  - if count_i ≥ shadow `zone_thresh`, `conf_i` increments, saturating at CONFIRM;
  - otherwise `conf_i` clears to 0;
  - `zone_ready[i]` = (next `conf_i` == CONFIRM). Registered.
  - `alert_level`, `harvest_alert` and `frame_done` are registered in the same update.
- EVAL → ACTIVE if a frame start occurs in the EVAL cycle (performs the ACTIVE entry actions); otherwise EVAL → WAIT_FRAME.
- VSYNC low at reset: no frame start is seen until a full high-then-low sequence, so the partial first frame is discarded.
- Reset mid-frame: all state and outputs return to reset values and the frame is discarded.
- A frame end seen in WAIT_FRAME is ignored.
- `fault_detected` clears only on `rst`.

## Timing
- Reset values: `zone_ready`=0, `alert_level`=0, `harvest_alert`=0, `frame_done`=0, `fault_detected`=0, FSM=WAIT_FRAME, all `conf_i`=0.
- Pixel accepted in cycle t is reflected in its zone counter at t+1.
- Frame-end detect in cycle t:
  - EVAL at t+1;
  - `zone_ready`/`alert_level`/`harvest_alert` update and `frame_done`=1 at t+2;
  - `frame_done` is low again at t+3.
- `fault_detected` rises the cycle after the saturating increment attempt.
- No back-pressure. The input stream is never stalled.

## Structure
- Shared package `farm_pkg`:
  - FSM state enum (WAIT_FRAME, ACTIVE, EVAL);
  - default parameter constants;
  - `harvest_alert` majority helper function.
- Sub-module `zone_confirm`, instantiated NUM_ZONES times. It holds the per-zone saturating green counter, the threshold compare and the CONFIRM counter, and exposes the ready bit.
- The top holds edge detect, FSM, column/zone counters, threshold shadows and output registers.

## Test plan
Bench parameters: NUM_ZONES=4, ZONE_PIX=4, CNT_W=16, CONFIRM=3, `green_thresh`=0x80, `zone_thresh`=8. Lines are 16 pixels, 2 lines per frame.
1. Reset → all outputs 0. Toggle href with vsync never high → no `frame_done`.
2. Zone0 pixels 0xFF, others 0x10 → zone0 count 8.
   - `zone_ready`=0000 after frames 1–2.
   - After frame 3: `zone_ready`=0001, `alert_level`=1, `harvest_alert`=0, `frame_done` at frame end+2.
3. Zones 0,1 ready, then a frame with zone0 count 7 → `zone_ready`=0010 at next `frame_done`. Zones 2,3 reach ready → `alert_level`=3, `harvest_alert`=1.
4. Lines of 24 pixels, all 0xFF in columns 16–23 only → all counts 0 and `zone_ready` stays 0000. Start with vsync low at reset → first partial frame is ignored.
5. `zone_thresh` changed 8→2 mid-frame → evaluation still uses 8. CNT_W=4 with 20 green pixels in zone0 → count 15 and `fault_detected`=1 until `rst`.
6. `rst` pulsed mid-ACTIVE → outputs 0 in the next cycle. The following frame end without a preceding frame start produces no `frame_done`.
